// File: rtl/clip_tri_reader.sv
// Reads clip-space vertices three at a time, rejects triangles wholly behind the eye,
// and streams surviving vertices to triangle setup on a valid/ready interface.
module clip_tri_reader #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       count,
    output logic              done,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [31:0]       mem_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_x,
    output logic [31:0]       out_y,
    output logic [31:0]       out_z,
    output logic [31:0]       out_w,
    output logic              out_first,
    output logic              out_last,
    output logic [15:0]       cull_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [3:0]        word_q, word_d;
    logic [31:0]       tri_q, tri_d;
    logic [31:0]       ntri_q, ntri_d;
    logic [1:0]        v_q, v_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cull_q, cull_d;
    logic              cap_en_q;
    logic [3:0]        cap_idx_q;
    logic [31:0]       vbuf_q [12];
    logic [31:0]       ntri_in;
    logic              all_behind;

    function automatic logic behind(input logic [31:0] w);
        return w[31] | (w[30:0] == 31'd0);
    endfunction

    assign ntri_in    = count / 32'd3;
    assign all_behind = behind(vbuf_q[3]) & behind(vbuf_q[7]) & behind(vbuf_q[11]);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        tri_d   = tri_q;
        ntri_d  = ntri_q;
        v_d     = v_q;
        addr_d  = addr_q;
        cull_d  = cull_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ntri_d = ntri_in;
                    cull_d = 16'd0;
                    if (ntri_in != 32'd0) begin
                        state_d = S_READ;
                        word_d  = 4'd0;
                        tri_d   = 32'd0;
                        addr_d  = BASE_ADDR;
                    end
                end
            end
            S_READ: begin
                word_d = word_q + 4'd1;
                // The last word's address is held; the next triangle advances it in S_NEXT.
                if (word_q == 4'd11) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: state_d = S_EVAL;
            S_EVAL: begin
                if (all_behind) begin
                    if (cull_q != 16'hFFFF) cull_d = cull_q + 16'd1;
                    state_d = S_NEXT;
                end else begin
                    state_d = S_EMIT;
                    v_d     = 2'd0;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (v_q == 2'd2) state_d = S_NEXT;
                    else             v_d     = v_q + 2'd1;
                end
            end
            S_NEXT: begin
                tri_d = tri_q + 32'd1;
                if (tri_q + 32'd1 == ntri_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_READ;
                    word_d  = 4'd0;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            word_q    <= 4'd0;
            tri_q     <= 32'd0;
            ntri_q    <= 32'd0;
            v_q       <= 2'd0;
            addr_q    <= BASE_ADDR;
            cull_q    <= 16'd0;
            cap_en_q  <= 1'b0;
            cap_idx_q <= 4'd0;
            for (int i = 0; i < 12; i++) vbuf_q[i] <= 32'd0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            tri_q     <= tri_d;
            ntri_q    <= ntri_d;
            v_q       <= v_d;
            addr_q    <= addr_d;
            cull_q    <= cull_d;
            // Read data lags the address by one cycle, so capture uses a delayed enable/index.
            cap_en_q  <= (state_q == S_READ);
            cap_idx_q <= word_q;
            if (cap_en_q) vbuf_q[cap_idx_q] <= mem_read_data;
        end
    end

    assign done          = (state_q == S_IDLE);
    assign mem_read_addr = addr_q;
    assign cull_count    = cull_q;
    assign out_valid     = (state_q == S_EMIT);
    assign out_first     = out_valid && (v_q == 2'd0);
    assign out_last      = out_valid && (v_q == 2'd2);
    assign out_x         = out_valid ? vbuf_q[{v_q, 2'b00}] : 32'd0;
    assign out_y         = out_valid ? vbuf_q[{v_q, 2'b01}] : 32'd0;
    assign out_z         = out_valid ? vbuf_q[{v_q, 2'b10}] : 32'd0;
    assign out_w         = out_valid ? vbuf_q[{v_q, 2'b11}] : 32'd0;

endmodule

// File: tb/tb_clip_tri_reader.sv
// Directed bench for clip_tri_reader with a vertex scoreboard and a second instance
// exercising address wrap at the top of the address space.
module tb_clip_tri_reader;

    typedef struct packed {
        logic [31:0] x, y, z, w;
        logic        f, l;
    } vtx_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] count = 32'd0;
    logic        done;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_x, out_y, out_z, out_w;
    logic        out_first, out_last;
    logic [15:0] cull_count;

    logic        start_w = 1'b0;
    logic [31:0] count_w = 32'd0;
    logic        done_w;
    logic [31:0] addr_w;
    logic [31:0] rdata_w = 32'd0;
    logic        valid_w;
    logic        ready_w = 1'b1;
    logic [31:0] x_w, y_w, z_w, w_w;
    logic        first_w, last_w;
    logic [15:0] cull_w;

    logic [31:0] mem   [64];
    logic [31:0] mem_w [64];

    int   checks = 0;
    int   errors = 0;
    int   n_emit = 0;
    int   ncyc;
    logic [31:0] maxa = 32'd0;
    vtx_t exp_q[$];
    logic [31:0] wrap_addr_q[$];
    logic [31:0] wrap_x_q[$];
    logic stall_q = 1'b0;
    vtx_t saved;

    always #5 clock = ~clock;

    clip_tri_reader #(.ADDR_W(32), .BASE_ADDR(32'd0)) dut (
        .clock(clock), .reset(reset), .start(start), .count(count), .done(done),
        .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_w(out_w),
        .out_first(out_first), .out_last(out_last), .cull_count(cull_count)
    );

    clip_tri_reader #(.ADDR_W(32), .BASE_ADDR(32'hFFFF_FFFA)) dut_w (
        .clock(clock), .reset(reset), .start(start_w), .count(count_w), .done(done_w),
        .mem_read_addr(addr_w), .mem_read_data(rdata_w),
        .out_valid(valid_w), .out_ready(ready_w),
        .out_x(x_w), .out_y(y_w), .out_z(z_w), .out_w(w_w),
        .out_first(first_w), .out_last(last_w), .cull_count(cull_w)
    );

    // Synchronous-read memory models: data for an address appears the following cycle.
    always @(posedge clock) begin
        mem_read_data <= mem[mem_read_addr[5:0]];
        rdata_w       <= mem_w[addr_w[5:0]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        vtx_t o;
        vtx_t e;
        o = '{x: out_x, y: out_y, z: out_z, w: out_w, f: out_first, l: out_last};
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (!done && mem_read_addr > maxa) maxa = mem_read_addr;
            if (stall_q) begin
                checks++;
                assert ({out_valid, o} === {1'b1, saved}) else begin
                    errors++;
                    $error("FAIL stall_stable observed=%0h expected=%0h", {out_valid, o},
                           {1'b1, saved});
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL unexpected_vertex observed=%0h expected=none", o);
                end else begin
                    e = exp_q.pop_front();
                    assert (o === e) else begin
                        errors++;
                        $error("FAIL vertex observed=%0h expected=%0h", o, e);
                    end
                end
                n_emit++;
            end
            stall_q = out_valid && !out_ready;
            saved   = o;
            if (!done_w && (wrap_addr_q.size() == 0 || wrap_addr_q[$] != addr_w))
                wrap_addr_q.push_back(addr_w);
            if (valid_w && ready_w) wrap_x_q.push_back(x_w);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_vtx(input int a, input logic [31:0] w);
        mem[a]     = 32'h1000_0000 + 32'(a);
        mem[a + 1] = 32'h2000_0000 + 32'(a);
        mem[a + 2] = 32'h3000_0000 + 32'(a);
        mem[a + 3] = w;
    endtask

    task automatic push_tri(input int t);
        for (int v = 0; v < 3; v++) begin
            int a;
            a = 12 * t + 4 * v;
            exp_q.push_back('{x: mem[a], y: mem[a + 1], z: mem[a + 2], w: mem[a + 3],
                              f: (v == 0), l: (v == 2)});
        end
    endtask

    task automatic run_start(input logic [31:0] n);
        count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < budget);
        chk("done_timeout", {63'd0, done}, 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]   = 32'h3F80_0000;
            mem_w[i] = 32'h4000_0000 + 32'(i);
        end
        repeat (3) tick();
        chk("rst_done", {63'd0, done}, 64'd1);
        chk("rst_valid", {61'd0, out_valid, out_first, out_last}, 64'd0);
        chk("rst_addr", {32'd0, mem_read_addr}, 64'd0);
        chk("rst_cull", {48'd0, cull_count}, 64'd0);
        chk("rst_xw", {out_x, out_w}, 64'd0);
        chk("rst_addr_wrap", {32'd0, addr_w}, 64'hFFFF_FFFA);
        reset = 1'b0;
        tick();

        // One visible triangle with full-rate acceptance.
        for (int v = 0; v < 3; v++) set_vtx(4 * v, 32'h3F80_0000);
        push_tri(0);
        run_start(32'd3);
        wait_done(60, ncyc);
        chk("t1_cycles", 64'(ncyc), 64'd18);
        chk("t1_cull", {48'd0, cull_count}, 64'd0);
        chk("t1_drained", 64'(exp_q.size()), 64'd0);

        // Culled triangle followed by a visible one with signed-zero w values.
        for (int v = 0; v < 3; v++) set_vtx(4 * v, 32'hBF80_0000);
        set_vtx(12, 32'h8000_0000);
        set_vtx(16, 32'h0000_0000);
        set_vtx(20, 32'h3F80_0000);
        push_tri(1);
        maxa = 32'd0;
        run_start(32'd6);
        wait_done(100, ncyc);
        chk("t2_cycles", 64'(ncyc), 64'd33);
        chk("t2_cull", {48'd0, cull_count}, 64'd1);
        chk("t2_maxaddr", {32'd0, maxa}, 64'd23);
        chk("t2_drained", 64'(exp_q.size()), 64'd0);

        // Fewer than three vertices: no pass, cull count cleared, address untouched.
        run_start(32'd2);
        repeat (3) begin
            chk("t3_c2_done", {63'd0, done}, 64'd1);
            tick();
        end
        chk("t3_c2_cull", {48'd0, cull_count}, 64'd0);
        chk("t3_c2_addr", {32'd0, mem_read_addr}, 64'd23);
        run_start(32'd0);
        repeat (3) begin
            chk("t3_c0_done", {63'd0, done}, 64'd1);
            tick();
        end

        // count=7: two triangles, trailing vertex never read.
        for (int v = 0; v < 3; v++) set_vtx(4 * v, 32'h4000_0000);
        push_tri(0);
        push_tri(1);
        maxa = 32'd0;
        run_start(32'd7);
        wait_done(100, ncyc);
        chk("t3_c7_maxaddr", {32'd0, maxa}, 64'd23);
        chk("t3_c7_cull", {48'd0, cull_count}, 64'd0);
        chk("t3_c7_drained", 64'(exp_q.size()), 64'd0);

        // Reset while triangle 1 of 3 is being emitted.
        for (int i = 24; i < 36; i += 4) set_vtx(i, 32'h3F80_0000);
        push_tri(0);
        n_emit = 0;
        run_start(32'd9);
        ncyc = 0;
        while (n_emit < 3 && ncyc < 100) begin
            tick();
            ncyc++;
        end
        out_ready = 1'b0;
        ncyc = 0;
        while (!out_valid && ncyc < 100) begin
            tick();
            ncyc++;
        end
        chk("t5_reached_emit", {62'd0, out_valid, out_first}, 64'd3);
        reset = 1'b1;
        tick();
        chk("t5_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_done", {63'd0, done}, 64'd1);
        chk("t5_addr", {32'd0, mem_read_addr}, 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        chk("t5_no_output", 64'(n_emit), 64'd3);

        // Backpressure 0,0,1 per vertex.
        out_ready = 1'b0;
        push_tri(0);
        run_start(32'd3);
        ncyc = 0;
        while (!out_valid && ncyc < 40) begin
            tick();
            ncyc++;
        end
        for (int v = 0; v < 3; v++) begin
            tick();
            tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        out_ready = 1'b1;
        wait_done(20, ncyc);
        chk("t4_drained", 64'(exp_q.size()), 64'd0);

        // start pulsed mid-read is ignored.
        push_tri(0);
        run_start(32'd3);
        repeat (5) tick();
        run_start(32'd99);
        wait_done(60, ncyc);
        chk("t6_cycles", 64'(ncyc + 6), 64'd18);
        chk("t6_drained", 64'(exp_q.size()), 64'd0);

        // Address wrap on the second instance.
        count_w = 32'd3;
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        ncyc = 0;
        while (!done_w && ncyc < 60) begin
            tick();
            ncyc++;
        end
        chk("wrap_done", {63'd0, done_w}, 64'd1);
        chk("wrap_naddr", 64'(wrap_addr_q.size()), 64'd12);
        for (int i = 0; i < 12 && i < wrap_addr_q.size(); i++)
            chk($sformatf("wrap_addr%0d", i), {32'd0, wrap_addr_q[i]},
                {32'd0, 32'hFFFF_FFFA + 32'(i)});
        chk("wrap_nvtx", 64'(wrap_x_q.size()), 64'd3);
        if (wrap_x_q.size() == 3) begin
            chk("wrap_x0", {32'd0, wrap_x_q[0]}, {32'd0, mem_w[58]});
            chk("wrap_x1", {32'd0, wrap_x_q[1]}, {32'd0, mem_w[62]});
            chk("wrap_x2", {32'd0, wrap_x_q[2]}, {32'd0, mem_w[2]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
